// File: rtl/seq_div32by16_if.sv
// Handshake bundle for the sequential 32/16 signed divider.
// Operands flow in on i_valid/o_ready, results out on o_valid/i_ready.
interface seq_div32by16_if #(
    parameter int W = 16
);
    logic                  i_valid;
    logic                  o_ready;
    logic signed [2*W-1:0] i_z;
    logic signed [W-1:0]   i_b;
    logic                  o_valid;
    logic                  i_ready;
    logic signed [W-1:0]   o_q;
    logic signed [W-1:0]   o_r;
    logic                  o_dbz;
    logic                  o_ovf;

    modport master (
        output i_valid, i_z, i_b, i_ready,
        input  o_ready, o_valid, o_q, o_r, o_dbz, o_ovf
    );

    modport slave (
        input  i_valid, i_z, i_b, i_ready,
        output o_ready, o_valid, o_q, o_r, o_dbz, o_ovf
    );
endinterface

// File: rtl/seq_div32by16.sv
// Sequential signed divider, 2W-bit dividend by W-bit divisor.
// Restoring radix-2 on magnitudes, one quotient bit per clock, then sign fix-up.
module seq_div32by16 #(
    parameter int W = 16
) (
    input logic             i_clk,
    input logic             i_rst_n,
    seq_div32by16_if.slave  bus
);
    localparam int DW = 2 * W;
    localparam int CW = $clog2(DW);
    localparam logic [DW-1:0] QPOS = DW'((1 << (W - 1)) - 1);
    localparam logic [DW-1:0] QNEG = DW'(1 << (W - 1));
    localparam logic [W-1:0]  SAT_P = {1'b0, {(W - 1){1'b1}}};
    localparam logic [W-1:0]  SAT_N = {1'b1, {(W - 1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t        r_state;
    state_t        w_state_nx;
    logic [CW-1:0] r_cnt;
    logic [DW-1:0] r_zmag;
    logic [W:0]    r_bmag;
    logic [W:0]    r_rem;
    logic [DW-1:0] r_qmag;
    logic          r_sign_q;
    logic          r_sign_r;
    logic          r_ready;
    logic          r_valid;
    logic [W-1:0]  r_q;
    logic [W-1:0]  r_r;
    logic          r_dbz;
    logic          r_ovf;

    logic          w_accept;
    logic          w_bzero;
    logic [DW-1:0] w_zmag;
    logic [W:0]    w_bext;
    logic [W:0]    w_bmag;
    logic [W+1:0]  w_shift;
    logic [W+1:0]  w_sub;
    logic          w_ge;
    logic          w_ovf;
    logic [W-1:0]  w_qlo;
    logic [W-1:0]  w_rlo;
    logic [W-1:0]  w_qsat;

    assign w_accept = bus.i_valid && r_ready && (r_state == S_IDLE);
    assign w_bzero  = (bus.i_b == '0);
    assign w_zmag   = bus.i_z[DW-1] ? (~bus.i_z + DW'(1)) : bus.i_z;
    assign w_bext   = {bus.i_b[W-1], bus.i_b};
    assign w_bmag   = bus.i_b[W-1] ? (~w_bext + (W+1)'(1)) : w_bext;

    // Partial remainder stays below |b| <= 2^(W-1), so W+2 bits never wrap
    assign w_shift  = {r_rem, r_zmag[DW-1]};
    assign w_sub    = w_shift - {1'b0, r_bmag};
    assign w_ge     = (w_shift >= {1'b0, r_bmag});

    assign w_ovf    = r_sign_q ? (r_qmag > QNEG) : (r_qmag > QPOS);
    assign w_qlo    = r_sign_q ? -r_qmag[W-1:0] : r_qmag[W-1:0];
    assign w_rlo    = r_sign_r ? -r_rem[W-1:0] : r_rem[W-1:0];
    assign w_qsat   = r_sign_q ? SAT_N : SAT_P;

    always_comb begin
        w_state_nx = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept)
                    w_state_nx = w_bzero ? S_DONE : S_CALC;
            end
            S_CALC: begin
                if (r_cnt == CW'(DW - 1))
                    w_state_nx = S_FIX;
            end
            S_FIX:   w_state_nx = S_DONE;
            S_DONE: begin
                if (bus.i_ready)
                    w_state_nx = S_IDLE;
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_zmag   <= '0;
            r_bmag   <= '0;
            r_rem    <= '0;
            r_qmag   <= '0;
            r_sign_q <= 1'b0;
            r_sign_r <= 1'b0;
            r_ready  <= 1'b0;
            r_valid  <= 1'b0;
            r_q      <= '0;
            r_r      <= '0;
            r_dbz    <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_ready <= (w_state_nx == S_IDLE);
            r_valid <= (w_state_nx == S_DONE);
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_zmag   <= w_zmag;
                        r_bmag   <= w_bmag;
                        r_sign_q <= bus.i_z[DW-1] ^ bus.i_b[W-1];
                        r_sign_r <= bus.i_z[DW-1];
                        r_rem    <= '0;
                        r_qmag   <= '0;
                        r_cnt    <= '0;
                        r_dbz    <= w_bzero;
                        r_ovf    <= 1'b0;
                        if (w_bzero) begin
                            r_q <= bus.i_z[DW-1] ? SAT_N : SAT_P;
                            r_r <= '0;
                        end
                    end
                end
                S_CALC: begin
                    r_zmag <= {r_zmag[DW-2:0], 1'b0};
                    r_rem  <= w_ge ? w_sub[W:0] : w_shift[W:0];
                    r_qmag <= {r_qmag[DW-2:0], w_ge};
                    r_cnt  <= r_cnt + CW'(1);
                end
                S_FIX: begin
                    r_ovf <= w_ovf;
                    r_q   <= w_ovf ? w_qsat : w_qlo;
                    r_r   <= w_rlo;
                end
                default: ;
            endcase
        end
    end

    assign bus.o_ready = r_ready;
    assign bus.o_valid = r_valid;
    assign bus.o_q     = r_q;
    assign bus.o_r     = r_r;
    assign bus.o_dbz   = r_dbz;
    assign bus.o_ovf   = r_ovf;
endmodule

// File: tb/tb_seq_div32by16.sv
// Randomised and directed bench for seq_div32by16.
// Expected results come from 64-bit integer division in the bench.
module tb_seq_div32by16;
    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    seq_div32by16_if #(.W(16)) bus ();

    seq_div32by16 #(.W(16)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model(input longint z, input longint b,
                                  output logic [15:0] q, output logic [15:0] r,
                                  output logic dbz, output logic ovf);
        longint qq;
        longint rr;
        if (b == 0) begin
            dbz = 1'b1;
            ovf = 1'b0;
            r   = 16'h0;
            q   = (z < 0) ? 16'h8000 : 16'h7fff;
        end else begin
            qq  = z / b;
            rr  = z % b;
            dbz = 1'b0;
            r   = rr[15:0];
            if (qq > 32767 || qq < -32768) begin
                ovf = 1'b1;
                q   = (qq > 0) ? 16'h7fff : 16'h8000;
            end else begin
                ovf = 1'b0;
                q   = qq[15:0];
            end
        end
    endfunction

    task automatic run_op(input logic signed [31:0] z, input logic signed [15:0] b,
                          input int stall,
                          output logic [15:0] q, output logic [15:0] r,
                          output logic dbz, output logic ovf, output int lat);
        int n;
        n = 0;
        while (bus.o_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        bus.i_z     = z;
        bus.i_b     = b;
        bus.i_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.i_valid = 1'b0;
        bus.i_z     = $urandom;
        bus.i_b     = 16'($urandom);
        lat = 1;
        while (bus.o_valid !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        q   = bus.o_q;
        r   = bus.o_r;
        dbz = bus.o_dbz;
        ovf = bus.o_ovf;
        repeat (stall) @(negedge clk);
        bus.i_ready = 1'b1;
        @(negedge clk);
        bus.i_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({bus.o_valid, bus.o_ready, bus.o_dbz, bus.o_ovf, bus.o_q, bus.o_r} !== 36'h0) begin
            n_err++;
            $display("FAIL reset_state: v=%b rdy=%b dbz=%b ovf=%b q=%h r=%h, want all 0",
                     bus.o_valid, bus.o_ready, bus.o_dbz, bus.o_ovf, bus.o_q, bus.o_r);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_vec++;
        if (bus.o_ready !== 1'b1 || bus.o_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release: rdy=%b v=%b, want rdy=1 v=0", bus.o_ready, bus.o_valid);
        end
    endtask

    task automatic test_round_trip();
        logic [15:0] q, r;
        logic dbz, ovf;
        int lat;
        run_op(-32'sd3962745, -16'sd321, 0, q, r, dbz, ovf, lat);
        n_vec++;
        if ({q, r, dbz, ovf} !== {16'd12345, 16'd0, 2'b00} || lat !== 34) begin
            n_err++;
            $display("FAIL round_trip: q=%0d r=%0d dbz=%b ovf=%b lat=%0d, want 12345 0 0 0 lat=34",
                     $signed(q), $signed(r), dbz, ovf, lat);
        end
    endtask

    task automatic test_signs();
        logic signed [31:0] tz [4] = '{100, -100, -100, 6};
        logic signed [15:0] tb [4] = '{-7, 7, -7, 7};
        logic signed [15:0] eq [4] = '{-14, -14, 14, 0};
        logic signed [15:0] er [4] = '{2, -2, -2, 6};
        logic [15:0] q, r;
        logic dbz, ovf;
        int lat;
        for (int i = 0; i < 4; i++) begin
            run_op(tz[i], tb[i], i, q, r, dbz, ovf, lat);
            n_vec++;
            if ({q, r, dbz, ovf} !== {eq[i], er[i], 2'b00} || lat !== 34) begin
                n_err++;
                $display("FAIL sign_%0d: %0d/%0d q=%0d r=%0d f=%b%b lat=%0d, want q=%0d r=%0d",
                         i, tz[i], tb[i], $signed(q), $signed(r), dbz, ovf, lat, eq[i], er[i]);
            end
        end
    endtask

    task automatic test_dbz();
        logic signed [31:0] tz [2] = '{5, -5};
        logic [15:0] eq [2] = '{16'h7fff, 16'h8000};
        logic [15:0] q, r;
        logic dbz, ovf;
        int lat;
        for (int i = 0; i < 2; i++) begin
            run_op(tz[i], 16'sd0, 1, q, r, dbz, ovf, lat);
            n_vec++;
            if ({q, r, dbz, ovf} !== {eq[i], 16'h0, 2'b10} || lat !== 1) begin
                n_err++;
                $display("FAIL dbz_%0d: q=%h r=%h dbz=%b ovf=%b lat=%0d, want q=%h r=0 dbz=1 lat=1",
                         i, q, r, dbz, ovf, lat, eq[i]);
            end
        end
    endtask

    task automatic test_overflow();
        logic signed [31:0] tz [4] = '{32'sh4000_0000, -32'sh4000_0000,
                                       32'sh8000_0000, 32'sh4000_0000};
        logic signed [15:0] tb [4] = '{-16'sd32768, -16'sd32768, -16'sd1, -16'sd1};
        logic [15:0] eq [4] = '{16'h8000, 16'h7fff, 16'h7fff, 16'h8000};
        logic        eo [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        logic [15:0] q, r;
        logic dbz, ovf;
        int lat;
        for (int i = 0; i < 4; i++) begin
            run_op(tz[i], tb[i], 0, q, r, dbz, ovf, lat);
            n_vec++;
            if ({q, r, dbz, ovf} !== {eq[i], 16'h0, 1'b0, eo[i]} || lat !== 34) begin
                n_err++;
                $display("FAIL ovf_%0d: q=%h r=%h dbz=%b ovf=%b lat=%0d, want q=%h r=0 ovf=%b",
                         i, q, r, dbz, ovf, lat, eq[i], eo[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        int n;
        n = 0;
        while (bus.o_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        bus.i_z     = 32'sd1000;
        bus.i_b     = 16'sd7;
        bus.i_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.i_valid = 1'b0;
        n = 1;
        while (bus.o_valid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 10; i++) begin
            bus.i_valid = i[0];
            bus.i_z     = $urandom;
            bus.i_b     = 16'($urandom);
            @(negedge clk);
            n_vec++;
            if ({bus.o_valid, bus.o_ready, bus.o_q, bus.o_r, bus.o_dbz, bus.o_ovf}
                !== {2'b10, 16'd142, 16'd6, 2'b00}) begin
                n_err++;
                $display("FAIL stall_%0d: v=%b rdy=%b q=%0d r=%0d f=%b%b, want v=1 rdy=0 q=142 r=6",
                         i, bus.o_valid, bus.o_ready, bus.o_q, bus.o_r, bus.o_dbz, bus.o_ovf);
            end
        end
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b1;
        @(negedge clk);
        bus.i_ready = 1'b0;
        n_vec++;
        if (bus.o_valid !== 1'b0 || bus.o_ready !== 1'b1) begin
            n_err++;
            $display("FAIL stall_release: v=%b rdy=%b, want v=0 rdy=1", bus.o_valid, bus.o_ready);
        end
        repeat (3) @(negedge clk);
        n_vec++;
        if (bus.o_valid !== 1'b0 || bus.o_ready !== 1'b1) begin
            n_err++;
            $display("FAIL stall_no_ghost: v=%b rdy=%b, want v=0 rdy=1", bus.o_valid, bus.o_ready);
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] q, r;
        logic dbz, ovf;
        int lat;
        bus.i_z     = 32'sd123456;
        bus.i_b     = 16'sd100;
        bus.i_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.i_valid = 1'b0;
        repeat (9) @(negedge clk);
        n_vec++;
        if (bus.o_ready !== 1'b0 || bus.o_valid !== 1'b0) begin
            n_err++;
            $display("FAIL calc_busy: rdy=%b v=%b, want 0 0", bus.o_ready, bus.o_valid);
        end
        rst_n = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({bus.o_valid, bus.o_ready, bus.o_dbz, bus.o_ovf, bus.o_q, bus.o_r} !== 36'h0) begin
            n_err++;
            $display("FAIL mid_reset: v=%b rdy=%b f=%b%b q=%h r=%h, want all 0",
                     bus.o_valid, bus.o_ready, bus.o_dbz, bus.o_ovf, bus.o_q, bus.o_r);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_vec++;
        if (bus.o_ready !== 1'b1 || bus.o_valid !== 1'b0) begin
            n_err++;
            $display("FAIL mid_release: rdy=%b v=%b, want 1 0", bus.o_ready, bus.o_valid);
        end
        run_op(32'sd1000, 16'sd10, 0, q, r, dbz, ovf, lat);
        n_vec++;
        if ({q, r, dbz, ovf} !== {16'd100, 16'd0, 2'b00} || lat !== 34) begin
            n_err++;
            $display("FAIL after_reset: q=%0d r=%0d f=%b%b lat=%0d, want 100 0 00 34",
                     q, r, dbz, ovf, lat);
        end
    endtask

    task automatic test_random(input int nops);
        logic signed [15:0] a, b, rr;
        logic signed [31:0] z;
        logic [15:0] q, r, mq, mr;
        logic dbz, ovf, mdbz, movf;
        longint p;
        int babs, rmag, lat, mode;
        for (int i = 0; i < nops; i++) begin
            mode = $urandom_range(0, 9);
            a = 16'($urandom);
            b = 16'($urandom);
            if (mode < 6) begin
                if (b == 0) b = 16'sd1;
                p    = longint'(a) * longint'(b);
                babs = (b < 0) ? -int'(b) : int'(b);
                rmag = $urandom_range(babs - 1, 0);
                rr   = (p < 0) ? 16'(-rmag) : 16'(rmag);
                z    = 32'(p + longint'(rr));
            end else begin
                z = $urandom;
                if (mode == 6) b = 16'sd0;
                if (mode == 7) b = 16'($signed(4'($urandom)));
                if (mode == 8) z = 32'($signed(20'($urandom)));
            end
            model(longint'(z), longint'(b), mq, mr, mdbz, movf);
            run_op(z, b, $urandom_range(0, 3), q, r, dbz, ovf, lat);
            n_vec++;
            if ({q, r, dbz, ovf} !== {mq, mr, mdbz, movf}
                || lat !== ((b == 0) ? 1 : 34)) begin
                n_err++;
                $display("FAIL rand_%0d: %0d/%0d q=%0d r=%0d f=%b%b lat=%0d, want q=%0d r=%0d f=%b%b",
                         i, z, b, $signed(q), $signed(r), dbz, ovf, lat,
                         $signed(mq), $signed(mr), mdbz, movf);
            end
            if (mode < 6) begin
                n_vec++;
                if (q !== a || r !== rr
                    || longint'($signed(q)) * longint'(b) + longint'($signed(r)) != longint'(z)) begin
                    n_err++;
                    $display("FAIL rand_inv_%0d: z=%0d b=%0d q=%0d r=%0d, want q=%0d r=%0d",
                             i, z, b, $signed(q), $signed(r), a, rr);
                end
            end
        end
    endtask

    initial begin
        n_vec       = 0;
        n_err       = 0;
        rst_n       = 1'b0;
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b0;
        bus.i_z     = '0;
        bus.i_b     = '0;
        test_reset();
        test_round_trip();
        test_signs();
        test_dbz();
        test_overflow();
        test_backpressure();
        test_reset_mid();
        test_random(1200);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
